// File: rtl/ads7883_pkg.sv
// ads7883_pkg: shared definitions for the ADS7883 averaging controller.
//   - state_e   : controller FSM states
//   - ADC_W_DEF : default ADC sample width
//   - DIV_MIN   : smallest conversion-start period the driver can sustain
//   - sticky_next(): next value of a sticky flag with clear-over-set priority
package ads7883_pkg;

  localparam int ADC_W_DEF = 12;
  localparam int DIV_MIN   = 80;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACC       = 3'd4,
    OUT       = 3'd5
  } state_e;

  // A clear in the same cycle as a set wins.
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return clr ? 1'b0 : (cur | set);
  endfunction

endpackage

// File: rtl/ads7883_tick_gen.sv
// ads7883_tick_gen: conversion-rate timer.
// Counts 0..DIV-1 while i_run is high and wraps; o_tick is high while the
// count sits at DIV-1. With i_run low the count is held at 0.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   i_run  in  enable for periodic ticks
//   o_tick out one-cycle rate tick
module ads7883_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running modulo-DIV counter, parked at zero while sampling is off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = i_run && (r_cnt == CNT_LAST);

endmodule

// File: rtl/ads7883_avg_ctrl.sv
// ads7883_avg_ctrl: sample-rate controller and averaging stage for the
// ADS7883 SPI driver. Issues periodic conversion starts, accumulates
// 2^LOG2_N results and offers the average on a valid/ready output.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   run                   periodic sampling enable
//   adc_en / adc_busy     start pulse out, driver busy flag in
//   adc_data              driver result, valid once adc_busy has fallen
//   avg_data / avg_valid  averaged sample and its valid flag
//   avg_ready             downstream accept
//   overrun, tick_miss,
//   adc_err               sticky error flags, cleared by clr_flags
// Build option: define ADS7883_AVG_ROUND_EN to round half up instead of
// truncating when dividing the sum down to the average.
module ads7883_avg_ctrl
  import ads7883_pkg::*;
#(
  parameter int DATA_W  = ADC_W_DEF,
  parameter int LOG2_N  = 4,
  parameter int DIV     = 100,
  parameter int BUSY_TO = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              adc_en,
  input  logic              adc_busy,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              overrun,
  output logic              tick_miss,
  output logic              adc_err,
  input  logic              clr_flags
);

  localparam int SUM_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int TO_W  = $clog2(BUSY_TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TO - 1);
`ifdef ADS7883_AVG_ROUND_EN
  // Half an LSB of the result; zero when LOG2_N is 0.
  localparam logic [SUM_W-1:0] RND = SUM_W'((1 << LOG2_N) >> 1);
`else
  localparam logic [SUM_W-1:0] RND = '0;
`endif

  state_e            r_state, w_state_nxt;
  logic              w_tick, r_busy_q, w_busy_fall, w_timeout;
  logic              w_hs, w_load, w_drop, w_unused;
  logic [SUM_W-1:0]  r_sum, w_sum_rnd;
  logic [CNT_W-1:0]  r_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_avg_data, w_avg;
  logic              r_adc_en, r_avg_valid, r_overrun, r_tick_miss, r_adc_err;

  ads7883_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_run  (run),
    .o_tick (w_tick)
  );

  assign w_busy_fall = r_busy_q & ~adc_busy;
  // The busy window is counted from the start-pulse cycle itself.
  assign w_timeout   = (r_state == WAIT_BUSY) && !adc_busy && (r_to_cnt == TO_LAST);
  assign w_hs        = r_avg_valid && avg_ready;
  // A result may land while the previous one is being accepted.
  assign w_load      = (r_state == OUT) && (!r_avg_valid || avg_ready);
  assign w_drop      = (r_state == OUT) && r_avg_valid && !avg_ready;
  assign w_sum_rnd   = r_sum + RND;
  assign w_avg       = w_sum_rnd[SUM_W-1:LOG2_N];
  // The fraction bits below LOG2_N are discarded by design.
  assign w_unused    = ^w_sum_rnd;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_tick) w_state_nxt = START; else w_state_nxt = IDLE;
      START:     w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (adc_busy)       w_state_nxt = WAIT_DONE;
        else if (w_timeout) w_state_nxt = IDLE;
        else                w_state_nxt = WAIT_BUSY;
      end
      WAIT_DONE: if (w_busy_fall) w_state_nxt = ACC; else w_state_nxt = WAIT_DONE;
      ACC:       if (r_cnt == CNT_LAST) w_state_nxt = OUT; else w_state_nxt = IDLE;
      OUT:       w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Busy edge detector and busy-rise timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_q <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_busy_q <= adc_busy;
      if (r_state == START || r_state == WAIT_BUSY) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                                          r_to_cnt <= '0;
    end
  end

  // Accumulator and sample count; survive run pauses and busy timeouts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (r_state == ACC) begin
      r_sum <= r_sum + SUM_W'(adc_data);
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == OUT) begin
      r_sum <= '0;
      r_cnt <= '0;
    end
  end

  // Registered outputs: start pulse, result holding register, sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adc_en    <= 1'b0;
      r_avg_data  <= '0;
      r_avg_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_tick_miss <= 1'b0;
      r_adc_err   <= 1'b0;
    end else begin
      r_adc_en <= (w_state_nxt == START);
      if (w_load) begin
        r_avg_data  <= w_avg;
        r_avg_valid <= 1'b1;
      end else if (w_hs) begin
        r_avg_valid <= 1'b0;
      end
      r_overrun   <= sticky_next(r_overrun, w_drop, clr_flags);
      r_tick_miss <= sticky_next(r_tick_miss, w_tick && (r_state != IDLE), clr_flags);
      r_adc_err   <= sticky_next(r_adc_err, w_timeout, clr_flags);
    end
  end

  assign adc_en    = r_adc_en;
  assign avg_data  = r_avg_data;
  assign avg_valid = r_avg_valid;
  assign overrun   = r_overrun;
  assign tick_miss = r_tick_miss;
  assign adc_err   = r_adc_err;

endmodule

// File: tb/tb_ads7883_avg_ctrl.sv
// Directed bench for ads7883_avg_ctrl (DIV=100, LOG2_N=2, BUSY_TO=4) with a
// behavioural ADS7883 driver model fed from a sample queue.
module tb_ads7883_avg_ctrl;
  localparam int DATA_W = 12, LOG2_N = 2, DIV = 100, BUSY_TO = 4;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, adc_busy = 1'b0;
  logic avg_ready = 1'b0, clr_flags = 1'b0;
  logic adc_en, avg_valid, overrun, tick_miss, adc_err;
  logic [DATA_W-1:0] adc_data = '0, avg_data;

  ads7883_avg_ctrl #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .DIV(DIV), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst(rst), .run(run), .adc_en(adc_en), .adc_busy(adc_busy),
    .adc_data(adc_data), .avg_data(avg_data), .avg_valid(avg_valid),
    .avg_ready(avg_ready), .overrun(overrun), .tick_miss(tick_miss),
    .adc_err(adc_err), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC driver model
  logic [DATA_W-1:0] samp_q[$];
  int en_hist[$];
  int conv_len = 20, busy_left = 0, en_cnt = 0, conv_done = 0;
  int last_fall = 0, last_en = 0, viol = 0;
  bit no_busy = 1'b0, start_seen = 1'b0, prev_en = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      adc_busy = 1'b0; busy_left = 0; start_seen = 1'b0; prev_en = 1'b0;
      samp_q.delete();
    end else begin
      if (adc_en && (prev_en || adc_busy)) viol++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          adc_busy = 1'b0;
          adc_data = (samp_q.size() > 0) ? samp_q.pop_front() : 12'd0;
          conv_done++;
          last_fall = cyc;
        end
      end
      if (start_seen) begin
        start_seen = 1'b0;
        if (!no_busy) begin adc_busy = 1'b1; busy_left = conv_len; end
      end
      if (adc_en) begin start_seen = 1'b1; en_cnt++; last_en = cyc; en_hist.push_back(cyc); end
      prev_en = adc_en;
    end
  end

  typedef struct packed {
    logic [11:0] s0, s1, s2, s3, exp_tr, exp_rd;
  } vec_t;
  vec_t vecs[6];

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push4(input logic [11:0] a, b, c, d);
    samp_q.push_back(a); samp_q.push_back(b); samp_q.push_back(c); samp_q.push_back(d);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !avg_valid; i++) step(1);
  endtask

  task automatic wait_conv(input int tgt);
    for (int i = 0; i < 1000 && conv_done < tgt; i++) step(1);
  endtask

  task automatic handshake();
    avg_ready = 1'b1; step(1); avg_ready = 1'b0;
  endtask

  function automatic logic [11:0] pick(input logic [11:0] tr, input logic [11:0] rd);
`ifdef ADS7883_AVG_ROUND_EN
    return rd;
`else
    return tr;
`endif
  endfunction

  int tgt, base, k;

  initial begin
    vecs[0] = '{12'd100, 12'd200, 12'd300, 12'd400, 12'd250, 12'd250};
    vecs[1] = '{12'd1, 12'd1, 12'd1, 12'd2, 12'd1, 12'd1};
    vecs[2] = '{12'd1, 12'd2, 12'd2, 12'd2, 12'd1, 12'd2};
    vecs[3] = '{12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095};
    vecs[4] = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    vecs[5] = '{12'd5, 12'd6, 12'd7, 12'd8, 12'd6, 12'd7};

    step(3); rst = 1'b0; step(2);
    chk("reset_adc_en", 32'(adc_en), 32'd0);
    chk("reset_valid", 32'(avg_valid), 32'd0);
    chk("reset_data", 32'(avg_data), 32'd0);
    chk("reset_flags", 32'({overrun, tick_miss, adc_err}), 32'd0);

    // Table-driven averages
    for (int v = 0; v < 6; v++) begin
      push4(vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3);
      en_hist.delete();
      run = 1'b1;
      wait_valid(600);
      chk($sformatf("vec%0d_valid", v), 32'(avg_valid), 32'd1);
      chk($sformatf("vec%0d_data", v), 32'(avg_data), 32'(pick(vecs[v].exp_tr, vecs[v].exp_rd)));
      chk($sformatf("vec%0d_latency", v), 32'(cyc - last_fall), 32'd3);
      run = 1'b0;
      if (v == 0) begin
        chk("en_count", 32'(en_hist.size()), 32'd4);
        for (int j = 1; j < 4; j++)
          if (j < en_hist.size()) chk("en_spacing", 32'(en_hist[j] - en_hist[j-1]), 32'(DIV));
      end
      handshake();
      chk($sformatf("vec%0d_ack", v), 32'(avg_valid), 32'd0);
    end

    // Overrun: second average dropped while the first is unconsumed
    push4(12'd100, 12'd200, 12'd300, 12'd400);
    push4(12'd50, 12'd50, 12'd50, 12'd50);
    run = 1'b1;
    wait_valid(600);
    chk("ovr_first", 32'(avg_data), 32'd250);
    for (int i = 0; i < 600 && !overrun; i++) step(1);
    run = 1'b0;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_data_kept", 32'(avg_data), 32'd250);
    chk("ovr_valid", 32'(avg_valid), 32'd1);
    clr_flags = 1'b1; step(1); clr_flags = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);

    // Back-to-back: accept in the same cycle as the next load
    push4(12'd7, 12'd7, 12'd7, 12'd7);
    tgt = conv_done + 4;
    run = 1'b1;
    wait_conv(tgt);
    chk("bb_conv", 32'(conv_done), 32'(tgt));
    for (int i = 0; i < 10 && cyc < last_fall + 2; i++) step(1);
    handshake();
    run = 1'b0;
    chk("bb_data", 32'(avg_data), 32'd7);
    chk("bb_valid", 32'(avg_valid), 32'd1);
    chk("bb_no_ovr", 32'(overrun), 32'd0);
    handshake();
    chk("bb_ack", 32'(avg_valid), 32'd0);

    // run paused mid-average keeps the partial sum
    push4(12'd10, 12'd20, 12'd30, 12'd40);
    tgt = conv_done + 2;
    run = 1'b1;
    wait_conv(tgt);
    run = 1'b0;
    base = en_cnt;
    step(300);
    chk("pause_no_en", 32'(en_cnt), 32'(base));
    chk("pause_valid", 32'(avg_valid), 32'd0);
    run = 1'b1;
    wait_valid(600);
    run = 1'b0;
    chk("pause_data", 32'(avg_data), 32'd25);
    handshake();

    // busy never rises
    no_busy = 1'b1;
    base = en_cnt;
    run = 1'b1;
    for (int i = 0; i < 200 && en_cnt == base; i++) step(1);
    k = last_en;
    for (int i = 0; i < 20 && !adc_err; i++) step(1);
    chk("to_err", 32'(adc_err), 32'd1);
    chk("to_time", 32'(cyc - k), 32'(BUSY_TO));
    no_busy = 1'b0;
    push4(12'd60, 12'd60, 12'd60, 12'd64);
    base = en_cnt;
    for (int i = 0; i < 200 && en_cnt == base; i++) step(1);
    chk("to_next_en", 32'(last_en - k), 32'(DIV));
    wait_valid(600);
    run = 1'b0;
    chk("to_data", 32'(avg_data), 32'd61);
    chk("to_sticky", 32'(adc_err), 32'd1);
    handshake();
    clr_flags = 1'b1; step(1); clr_flags = 1'b0;
    chk("to_clear", 32'(adc_err), 32'd0);

    // Conversion longer than DIV: tick missed, no start while busy
    conv_len = 130;
    push4(12'd8, 12'd8, 12'd8, 12'd12);
    en_hist.delete();
    run = 1'b1;
    wait_valid(1200);
    run = 1'b0;
    conv_len = 20;
    chk("tm_data", 32'(avg_data), 32'd9);
    chk("tm_flag", 32'(tick_miss), 32'd1);
    if (en_hist.size() > 1) chk("tm_spacing", 32'(en_hist[1] - en_hist[0]), 32'(2 * DIV));
    else chk("tm_en_count", 32'(en_hist.size()), 32'd4);

    // Reset during WAIT_DONE (result and tick_miss still pending)
    samp_q.push_back(12'd4000); samp_q.push_back(12'd4000); samp_q.push_back(12'd4000);
    tgt = conv_done + 2;
    run = 1'b1;
    wait_conv(tgt);
    for (int i = 0; i < 200 && !adc_busy; i++) step(1);
    chk("rst_in_conv", 32'(adc_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_adc_en", 32'(adc_en), 32'd0);
    chk("rst_valid", 32'(avg_valid), 32'd0);
    chk("rst_data", 32'(avg_data), 32'd0);
    chk("rst_flags", 32'({overrun, tick_miss, adc_err}), 32'd0);
    step(2);
    push4(12'd20, 12'd20, 12'd20, 12'd24);
    rst = 1'b0;
    wait_valid(600);
    run = 1'b0;
    chk("rst_fresh_data", 32'(avg_data), 32'd21);

    chk("model_protocol", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
